aes_round_sched: RTL

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

---
 rtl/aes_round_sched.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_round_sched.sv
// -----------------------------------------------------------------------------
// aes_round_sched
//
// Round scheduler for an iterative AES datapath. It accepts one block at a
// time and then walks the datapath through these steps:
//   - one initial AddRoundKey;
//   - Nr-1 full rounds;
//   - one final round without MixColumns;
//   - a one-cycle completion pulse.
// It supplies the matching round-key index for each step, counting up for
// encrypt and down for decrypt.
//
// Handshake: t_ready and k_ready are level signals from the host. A block is
// accepted on a CLK edge where the scheduler is idle (Core_Full=0), both
// t_ready and k_ready are high, abort is low and Nr is legal (10/12/14).
// While Core_Full=1 every request input, Nr and op are ignored. key_done is a
// level from the key-expansion core and is only looked at while waiting for
// round keys.
//
// Optional feature: define AES_SCHED_STATS_EN to build the completed-block
// counter on blk_cnt. When the macro is undefined, blk_cnt is tied to zero.
//
// Parameters
//   KEY_TIMEOUT  max cycles spent waiting for key_done before giving up
//   CNT_W        width of blk_cnt
//
// Ports
//   CLK        in   clock, all state on its rising edge
//   RSTB       in   asynchronous active-low reset
//   t_ready    in   data block presented (level)
//   k_ready    in   cipher key presented (level)
//   Nr         in   round count, legal values 10/12/14
//   op         in   1 = encrypt, 0 = decrypt
//   key_done   in   key expansion holds all round keys (level)
//   abort      in   synchronous cancel of the block in flight
//   Core_Full  out  scheduler busy
//   ark_en     out  initial AddRoundKey strobe
//   rnd_en     out  full-round strobe
//   last_rnd   out  final-round strobe (MixColumns skipped)
//   key_idx    out  round-key index for the active strobe, 0 otherwise
//   op_q       out  op latched for the block in flight
//   c_ready    out  one-cycle pulse on block completion
//   err        out  one-cycle pulse on illegal Nr or key timeout
//   blk_cnt    out  completed-block counter
//   state_dbg  out  FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module aes_round_sched #(
  parameter int KEY_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             t_ready,
  input  logic             k_ready,
  input  logic [3:0]       Nr,
  input  logic             op,
  input  logic             key_done,
  input  logic             abort,
  output logic             Core_Full,
  output logic             ark_en,
  output logic             rnd_en,
  output logic             last_rnd,
  output logic [3:0]       key_idx,
  output logic             op_q,
  output logic             c_ready,
  output logic             err,
  output logic [CNT_W-1:0] blk_cnt,
  output logic [2:0]       state_dbg
);

  // Wait counter must be able to hold KEY_TIMEOUT-1.
  localparam int WAIT_W = (KEY_TIMEOUT < 2) ? 1 : $clog2(KEY_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(KEY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KWAIT = 3'd1,
    S_INIT  = 3'd2,
    S_ROUND = 3'd3,
    S_FINAL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        r_q, r_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        nr_q;
  logic              op_r;
  logic              err_q, err_d;
  logic              latch_blk;
  logic              start_req;
  logic              nr_legal;

  assign start_req = t_ready && k_ready && !abort;
  assign nr_legal  = (Nr == 4'd10) || (Nr == 4'd12) || (Nr == 4'd14);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    wait_d    = wait_q;
    err_d     = 1'b0;
    latch_blk = 1'b0;

    case (state_q)
      S_IDLE: begin
        r_d    = 4'd0;
        wait_d = '0;
        if (start_req) begin
          if (nr_legal) begin
            latch_blk = 1'b1;
            state_d   = S_KWAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_KWAIT: begin
        // Priority: abort, then key_done (it wins over a coinciding
        // timeout), then the timeout itself.
        if (abort) begin
          state_d = S_IDLE;
          wait_d  = '0;
        end else if (key_done) begin
          state_d = S_INIT;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_IDLE;
          wait_d  = '0;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_INIT: begin
        r_d     = 4'd1;
        state_d = abort ? S_IDLE : S_ROUND;
      end

      S_ROUND: begin
        r_d = r_q + 4'd1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (r_q == nr_q - 4'd1) begin
          state_d = S_FINAL;
        end
      end

      S_FINAL: begin
        state_d = abort ? S_IDLE : S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and block registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= S_IDLE;
      r_q     <= 4'd0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      nr_q    <= 4'd0;
      op_r    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (latch_blk) begin
        nr_q <= Nr;
        op_r <= op;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so there is no path from
  // any input to any output within a cycle.
  // ---------------------------------------------------------------------------
  assign Core_Full = (state_q != S_IDLE);
  assign ark_en    = (state_q == S_INIT);
  assign rnd_en    = (state_q == S_ROUND);
  assign last_rnd  = (state_q == S_FINAL);
  assign c_ready   = (state_q == S_DONE);
  assign err       = err_q;
  assign op_q      = op_r;
  assign state_dbg = state_q;

  // Decrypt walks the key schedule backwards: Nr, Nr-1, ..., 0.
  always_comb begin
    key_idx = 4'd0;
    case (state_q)
      S_INIT:  key_idx = op_r ? 4'd0 : nr_q;
      S_ROUND: key_idx = op_r ? r_q  : (nr_q - r_q);
      S_FINAL: key_idx = op_r ? nr_q : 4'd0;
      default: key_idx = 4'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Completed-block counter. It counts every DONE cycle, because the c_ready
  // of that cycle has already been issued.
  // ---------------------------------------------------------------------------
`ifdef AES_SCHED_STATS_EN
  logic [CNT_W-1:0] blk_cnt_q;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      blk_cnt_q <= '0;
    end else if (state_q == S_DONE) begin
      blk_cnt_q <= blk_cnt_q + CNT_W'(1);
    end
  end

  assign blk_cnt = blk_cnt_q;
`else
  assign blk_cnt = '0;
`endif

endmodule
